// File: rtl/mem_ctrl_if.sv
// Bus between the MEM pipeline stage, mem_ctrl and a byte-wide synchronous RAM.
// Handshake: the master raises ce_i with we_i/sel_i/addr_i/data_i and holds ce_i
// until the cycle done_o=1; stall_o asks the pipeline to hold while the access
// is in flight, and done_o is a one-cycle completion pulse (data_o valid there).
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              ce_i;
  logic              we_i;
  logic [2:0]        sel_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       data_i;
  logic [31:0]       data_o;
  logic              stall_o;
  logic              done_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic              ram_we_o;
  logic [7:0]        ram_din_o;
  logic [7:0]        ram_dout_i;

  // Master is the environment: pipeline request side plus the RAM read port.
  modport master (
    output ce_i, we_i, sel_i, addr_i, data_i, ram_dout_i,
    input  data_o, stall_o, done_o, ram_addr_o, ram_we_o, ram_din_o
  );

  modport slave (
    input  ce_i, we_i, sel_i, addr_i, data_i, ram_dout_i,
    output data_o, stall_o, done_o, ram_addr_o, ram_we_o, ram_din_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// Serialises RISC-V byte/half/word loads and stores onto a byte-wide RAM
// with one-cycle read latency; loads are sign/zero-extended per funct3.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic              we_q;
  logic [2:0]        sel_q;
  logic [31:0]       data_q;
  logic [1:0]        cnt;
  logic [1:0]        cnt_inc;
  logic [1:0]        last_idx;
  logic              xfer_last;
  logic              legal_req;

  logic [31:0]       asm_q;
  logic [31:0]       asm_nxt;
  logic              cap_en;
  logic [1:0]        cap_idx;
  logic [31:0]       ld_ext;

  logic [31:0]       data_o_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [7:0]        ram_din_q;

  logic              stall;
  logic              done;
  logic              ram_we;

  // funct3 x11 and 11x encode no RV32 load/store width.
  assign legal_req = ~(bus.sel_i[1] & bus.sel_i[0]) & ~(bus.sel_i[2] & bus.sel_i[1]);

  always_comb begin
    case (sel_q[1:0])
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  assign xfer_last = (cnt == last_idx);
  assign cnt_inc   = cnt + 2'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    ram_we    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ce_i) begin
          if (legal_req) begin
            stall     = 1'b1;
            state_nxt = XFER;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      XFER: begin
        stall  = 1'b1;
        // Gated by rst so the reset edge itself cannot commit another byte.
        ram_we = we_q & rst;
        if (xfer_last) begin
          state_nxt = we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        stall     = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read data lags its address by one cycle: byte k arrives in XFER k+1 or WAIT.
  assign cap_en  = ((state == XFER) && !we_q && (cnt != 2'd0)) || (state == WAIT);
  assign cap_idx = (state == WAIT) ? last_idx : (cnt - 2'd1);

  always_comb begin
    asm_nxt = asm_q;
    if (cap_en) begin
      asm_nxt[{cap_idx, 3'b000} +: 8] = bus.ram_dout_i;
    end
  end

  always_comb begin
    case (sel_q[1:0])
      2'b00:   ld_ext = {{24{~sel_q[2] & asm_nxt[7]}},  asm_nxt[7:0]};
      2'b01:   ld_ext = {{16{~sel_q[2] & asm_nxt[15]}}, asm_nxt[15:0]};
      default: ld_ext = asm_nxt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q       <= 1'b0;
      sel_q      <= 3'b000;
      data_q     <= 32'h0;
      cnt        <= 2'd0;
      asm_q      <= 32'h0;
      data_o_q   <= 32'h0;
      ram_addr_q <= '0;
      ram_din_q  <= 8'h00;
    end else begin
      asm_q <= asm_nxt;
      case (state)
        IDLE: begin
          if (bus.ce_i) begin
            we_q   <= bus.we_i;
            sel_q  <= bus.sel_i;
            data_q <= bus.data_i;
            cnt    <= 2'd0;
            if (legal_req) begin
              ram_addr_q <= bus.addr_i;
              if (bus.we_i) begin
                ram_din_q <= bus.data_i[7:0];
              end
            end else begin
              data_o_q <= 32'h0;
            end
          end
        end
        XFER: begin
          if (!xfer_last) begin
            cnt        <= cnt_inc;
            ram_addr_q <= ram_addr_q + ADDR_W'(1);
            if (we_q) begin
              ram_din_q <= data_q[{cnt_inc, 3'b000} +: 8];
            end
          end
        end
        WAIT: begin
          data_o_q <= ld_ext;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.stall_o    = stall;
  assign bus.done_o     = done;
  assign bus.ram_we_o   = ram_we;
  assign bus.ram_addr_o = ram_addr_q;
  assign bus.ram_din_o  = ram_din_q;
  assign bus.data_o     = data_o_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed and randomised checks of mem_ctrl against a byte-wide RAM model
// with one-cycle read latency.
module tb_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];
  logic [31:0] wa_q[$];
  logic [7:0]  wd_q[$];
  logic [31:0] last_load;

  logic [7:0] mem [logic [31:0]];

  mem_ctrl_if #(.ADDR_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  always @(posedge clk) begin
    bus.ram_dout_i <= rd_mem(bus.ram_addr_o);
    if (bus.ram_we_o) mem[bus.ram_addr_o] = bus.ram_din_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every RAM write strobe must match the next expected (addr, byte) pair.
  always @(negedge clk) begin
    #1;
    if (bus.ram_we_o) begin
      if (wa_q.size() == 0) begin
        chk("unexpected_write", 32'(bus.ram_we_o), 32'h0);
      end else begin
        chk("wr_addr", bus.ram_addr_o, wa_q.pop_front());
        chk("wr_byte", 32'(bus.ram_din_o), 32'(wd_q.pop_front()));
      end
    end
  end

  task automatic push_writes(input logic [31:0] addr, input logic [31:0] data, input int n);
    for (int k = 0; k < n; k++) begin
      wa_q.push_back(addr + 32'(k));
      wd_q.push_back(data[8*k +: 8]);
    end
  endtask

  // One access; chk_data pops exp_q at done, otherwise data_o must be unchanged.
  task automatic access(input logic we, input logic [2:0] sel, input logic [31:0] addr,
                        input logic [31:0] data, input int exp_stall, input logic chk_data,
                        input string tag);
    int   cyc;
    int   stl;
    logic seen;
    logic [31:0] e;
    cyc  = 0;
    stl  = 0;
    seen = 1'b0;
    @(negedge clk);
    bus.ce_i   = 1'b1;
    bus.we_i   = we;
    bus.sel_i  = sel;
    bus.addr_i = addr;
    bus.data_i = data;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (bus.done_o) begin
        seen = 1'b1;
        chk({tag, "_stall_in_done"}, 32'(bus.stall_o), 32'h0);
        chk({tag, "_we_in_done"}, 32'(bus.ram_we_o), 32'h0);
        if (chk_data) begin
          e = exp_q.pop_front();
          last_load = e;
        end else begin
          e = last_load;
        end
        chk({tag, "_data"}, bus.data_o, e);
      end else begin
        cyc++;
        if (bus.stall_o) stl++;
      end
      @(negedge clk);
      // Scramble the other inputs after accept; they must be ignored.
      bus.we_i   = 1'($urandom_range(1, 0));
      bus.addr_i = $urandom;
      bus.data_i = $urandom;
      bus.sel_i  = 3'($urandom_range(7, 0));
    end
    bus.ce_i = 1'b0;
    #1;
    chk({tag, "_done_seen"}, 32'(seen), 32'h1);
    chk({tag, "_stall_cycles"}, 32'(stl), 32'(exp_stall));
    chk({tag, "_cycles_to_done"}, 32'(cyc), (exp_stall == 0) ? 32'h1 : 32'(exp_stall));
    chk({tag, "_idle_after"}, 32'(state_dbg), 32'h0);
    chk({tag, "_no_restart"}, 32'(bus.stall_o), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst        = 1'b0;
    bus.ce_i   = 1'b0;
    bus.we_i   = 1'b0;
    bus.sel_i  = 3'b000;
    bus.addr_i = 32'h0;
    bus.data_i = 32'h0;
    last_load  = 32'h0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_state",    32'(state_dbg),      32'h0);
    chk("rst_data_o",   bus.data_o,          32'h0);
    chk("rst_done",     32'(bus.done_o),     32'h0);
    chk("rst_stall",    32'(bus.stall_o),    32'h0);
    chk("rst_ram_we",   32'(bus.ram_we_o),   32'h0);
    chk("rst_ram_addr", bus.ram_addr_o,      32'h0);
    chk("rst_ram_din",  32'(bus.ram_din_o),  32'h0);
    rst = 1'b1;

    push_writes(32'h100, 32'h11223344, 4);
    access(1'b1, 3'b010, 32'h100, 32'h11223344, 5, 1'b0, "sw_100");
    exp_q.push_back(32'h11223344);
    access(1'b0, 3'b010, 32'h100, 32'h0, 6, 1'b1, "lw_100");
    exp_q.push_back(32'h00112233);
    access(1'b0, 3'b010, 32'h101, 32'h0, 6, 1'b1, "lw_101_misaligned");

    mem[32'h200] = 8'h80;
    mem[32'h201] = 8'h00;
    exp_q.push_back(32'hFFFFFF80);
    access(1'b0, 3'b000, 32'h200, 32'h0, 3, 1'b1, "lb_200");
    exp_q.push_back(32'h00000080);
    access(1'b0, 3'b100, 32'h200, 32'h0, 3, 1'b1, "lbu_200");
    exp_q.push_back(32'h00000080);
    access(1'b0, 3'b001, 32'h200, 32'h0, 4, 1'b1, "lh_200_pos");
    mem[32'h201] = 8'hF0;
    exp_q.push_back(32'h0000F080);
    access(1'b0, 3'b101, 32'h200, 32'h0, 4, 1'b1, "lhu_200");
    exp_q.push_back(32'hFFFFF080);
    access(1'b0, 3'b001, 32'h200, 32'h0, 4, 1'b1, "lh_200_neg");

    push_writes(32'hFFFFFFFF, 32'h0000ABCD, 2);
    access(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000ABCD, 3, 1'b0, "sh_wrap");
    chk("wrap_byte_hi", 32'(rd_mem(32'h0)), 32'h000000AB);
    exp_q.push_back(32'hFFFFABCD);
    access(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 4, 1'b1, "lh_wrap");

    push_writes(32'h203, 32'h000000A5, 1);
    access(1'b1, 3'b000, 32'h203, 32'hDEADBEA5, 2, 1'b0, "sb_203");

    exp_q.push_back(32'h0);
    access(1'b0, 3'b011, 32'h200, 32'h0, 0, 1'b1, "illegal_011");
    exp_q.push_back(32'h00000080);
    access(1'b0, 3'b100, 32'h200, 32'h0, 3, 1'b1, "lbu_after_illegal");
    exp_q.push_back(32'h0);
    access(1'b1, 3'b110, 32'h200, 32'hFFFFFFFF, 0, 1'b1, "illegal_110");
    exp_q.push_back(32'h0);
    access(1'b0, 3'b111, 32'h200, 32'h0, 0, 1'b1, "illegal_111");

    for (int r = 0; r < 4; r++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = $urandom_range(32'h1FF0, 32'h1000);
      d = $urandom;
      push_writes(a, d, 4);
      access(1'b1, 3'b010, a, d, 5, 1'b0, "rand_sw");
      exp_q.push_back(d);
      access(1'b0, 3'b010, a, 32'h0, 6, 1'b1, "rand_lw");
    end

    // Reset while a word store is in XFER cycle 1: only byte 0 may land.
    push_writes(32'h300, 32'hA1B2C3D4, 1);
    @(negedge clk);
    bus.ce_i   = 1'b1;
    bus.we_i   = 1'b1;
    bus.sel_i  = 3'b010;
    bus.addr_i = 32'h300;
    bus.data_i = 32'hA1B2C3D4;
    @(negedge clk);
    #1;
    chk("abort_xfer0_state", 32'(state_dbg), 32'h1);
    @(negedge clk);
    rst      = 1'b0;
    bus.ce_i = 1'b0;
    #1;
    chk("abort_xfer1_done", 32'(bus.done_o), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_state",    32'(state_dbg),     32'h0);
    chk("abort_done",     32'(bus.done_o),    32'h0);
    chk("abort_data_o",   bus.data_o,         32'h0);
    chk("abort_ram_addr", bus.ram_addr_o,     32'h0);
    chk("abort_ram_din",  32'(bus.ram_din_o), 32'h0);
    @(negedge clk);
    #1;
    chk("abort_no_done_later", 32'(bus.done_o), 32'h0);
    chk("abort_byte1_kept", 32'(rd_mem(32'h301)), 32'h0);
    last_load = 32'h0;
    exp_q.push_back(32'h000000D4);
    access(1'b0, 3'b010, 32'h300, 32'h0, 6, 1'b1, "lw_after_abort");

    repeat (2) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    chk("wr_q_drained",  32'(wa_q.size()),  32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, width of addr_i and ram_addr_o.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low (rst=0 sampled at a rising edge resets the block).
REQ-004 ce_i  input  1  access request from the MEM stage; held high until the cycle done_o=1.
REQ-005 we_i  input  1  1=store, 0=load; qualified by ce_i.
REQ-006 sel_i  input  3  access type (RISC-V funct3): 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
REQ-007 addr_i  input  ADDR_W  byte address of the access.
REQ-008 data_i  input  32  store data, little-endian, low bytes used.
REQ-009 data_o  output  32  load result, valid in the done_o cycle.
REQ-010 stall_o  output  1  pipeline hold request.
REQ-011 done_o  output  1  access complete, one-cycle pulse.
REQ-012 ram_addr_o  output  ADDR_W  byte address to byte-wide RAM.
REQ-013 ram_we_o  output  1  RAM byte write strobe.
REQ-014 ram_din_o  output  8  RAM write byte.
REQ-015 ram_dout_i  input  8  RAM read byte, valid exactly one cycle after its address is presented.

Function
REQ-016 The block SHALL implement states IDLE, XFER, WAIT, DONE.
REQ-017 Byte count N SHALL be 1 for sel_i[1:0]=00, 2 for 01, 4 for 10.
REQ-018 sel_i values 011, 110, 111 SHALL be illegal: IDLE->DONE with no RAM access, data_o=0.
REQ-019 In IDLE with ce_i=1, the block SHALL latch we_i, sel_i, addr_i, data_i, assert stall_o combinationally in that cycle, and enter XFER (or DONE per REQ-018).
REQ-020 stall_o SHALL equal (state is XFER or WAIT) or (state is IDLE and ce_i=1 and the request is legal).
REQ-021 XFER SHALL last exactly N cycles; in cycle k (k=0..N-1) ram_addr_o = latched addr + k, modulo 2^ADDR_W.
REQ-022 Store: in XFER cycle k, ram_we_o=1 and ram_din_o = latched data byte k (bits 8k+7:8k); then DONE.
REQ-023 Load: ram_we_o SHALL be 0 throughout; ram_dout_i SHALL be captured into byte k of an assembly register one cycle after XFER cycle k; after XFER the block SHALL spend one WAIT cycle capturing the last byte, then enter DONE.
REQ-024 Load extension: sel_i[2]=0 SHALL sign-extend from bit 8N-1; sel_i[2]=1 SHALL zero-extend.
REQ-025 data_o SHALL be registered, updated on entry to DONE, and hold its value until the next load completes; stores SHALL NOT change it.
REQ-026 In DONE: done_o=1, stall_o=0, ram_we_o=0; next state IDLE unconditionally (ce_i still high in DONE SHALL NOT start a new access).
REQ-027 Latency: stall_o high for N+1 cycles (store) or N+2 cycles (load), then one DONE cycle.
REQ-028 Misaligned addresses SHALL be legal and handled byte-by-byte with no exception.
REQ-029 Outside XFER, ram_we_o SHALL be 0 and ram_addr_o, ram_din_o SHALL hold their last values.
REQ-030 Inputs other than ce_i SHALL be ignored after the accept cycle until IDLE is re-entered.

Reset
REQ-031 After a rising edge with rst=0: state IDLE, data_o=0, done_o=0, ram_we_o=0, ram_addr_o=0, ram_din_o=0, assembly register 0; stall_o then follows REQ-020.
REQ-032 Reset mid-access SHALL abort it with no further RAM writes after the reset edge and no done_o pulse for the aborted access.

Verification
REQ-033 SW addr=0x100, data=0x11223344 -> ram_we_o high 4 cycles, bytes 44,33,22,11 to 0x100..0x103; stall_o 5 cycles, done_o 1 cycle.
REQ-034 LW from 0x100 after REQ-033 -> data_o=0x11223344, stall_o 6 cycles, ram_we_o never high.
REQ-035 RAM byte 0x80 at 0x200: LB -> 0xFFFFFF80; LBU -> 0x00000080; LH with 0x201=0x00 -> 0xFFFF0080? no: 0x00000080 sign-extended from bit 15 -> 0x00000080; LHU with 0x201=0xF0 -> 0x0000F080, LH -> 0xFFFFF080.
REQ-036 SH addr=0xFFFFFFFF (ADDR_W=32), data=0xABCD -> bytes CD at 0xFFFFFFFF, AB at 0x00000000.
REQ-037 rst=0 during XFER cycle 1 of a SW -> only byte 0 written, state IDLE, no done_o; following LW completes normally.
REQ-038 sel_i=011 with ce_i=1 -> no stall, no RAM access, done_o next cycle, data_o=0.
